acc_exec_stage: RTL

- Execute-stage sequencer that sits directly upstream of the 8-bit ADD/SUB arithmetic unit.
- Accepts one instruction at a time over a valid/ready handshake. Holds a 16x8 register file, the accumulator and the carry flag.
- Drives the arithmetic unit's op-select, operand and accumulator-in inputs. Registers its result and carry/borrow back into the accumulator and carry flag.

---
 rtl/acc_exec_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/acc_exec_stage.sv
// Execute-stage sequencer driving an external 8-bit ADD/SUB unit.
// Define ACC_ZERO_FLAG_EN to add the registered 'zero' output.
module acc_exec_stage #(
    parameter int         NREGS   = 16,
    parameter logic [7:0] ACC_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_opcode,
    input  logic [3:0] in_reg,
    input  logic       reg_wr_en,
    input  logic [3:0] reg_wr_addr,
    input  logic [7:0] reg_wr_data,
    output logic       alu_op_select,
    output logic [7:0] alu_operand,
    output logic [7:0] alu_acc_in,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic [7:0] acc,
    output logic       carry,
    output logic       done,
    output logic       err
`ifdef ACC_ZERO_FLAG_EN
    ,
    output logic       zero
`endif
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_LDA = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_CLR = 4'd5;

    typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

    state_t        state;
    logic          ready_q;
    logic [3:0]    opcode_q;
    logic [IW-1:0] index_q;
    logic [7:0]    operand_q;
    logic [7:0]    rf [NREGS];

    logic [7:0]    acc_nx;
    logic          carry_nx;
    logic          acc_we;
    logic          sta_we;
    logic          illegal;

    assign in_ready      = ready_q;
    assign alu_op_select = (opcode_q == OP_SUB);
    assign alu_operand   = operand_q;
    assign alu_acc_in    = acc;

    // Commit values for the latched opcode; only applied in EXEC.
    always_comb begin
        acc_nx   = acc;
        carry_nx = carry;
        acc_we   = 1'b0;
        sta_we   = 1'b0;
        illegal  = 1'b0;
        case (opcode_q)
            OP_ADD, OP_SUB: begin
                acc_nx   = alu_result;
                carry_nx = alu_carry;
                acc_we   = 1'b1;
            end
            OP_LDA: begin
                acc_nx = operand_q;
                acc_we = 1'b1;
            end
            OP_STA: sta_we = 1'b1;
            OP_CLR: begin
                acc_nx   = 8'h00;
                carry_nx = 1'b0;
                acc_we   = 1'b1;
            end
            OP_NOP: ;
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            opcode_q  <= OP_NOP;
            index_q   <= '0;
            operand_q <= 8'h00;
            acc       <= ACC_RST;
            carry     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (reg_wr_en) rf[reg_wr_addr[IW-1:0]] <= reg_wr_data;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opcode_q <= in_opcode;
                        index_q  <= in_reg[IW-1:0];
                        ready_q  <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    // Read sees the pre-edge entry: no write bypass.
                    operand_q <= rf[index_q];
                    state     <= EXEC;
                end
                EXEC: begin
                    if (acc_we) acc <= acc_nx;
                    carry <= carry_nx;
                    // Placed after the external write so STA wins a collision.
                    if (sta_we) rf[index_q] <= acc;
                    done  <= 1'b1;
                    err   <= illegal;
                    state <= DONE;
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef ACC_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero <= (ACC_RST == 8'h00);
        else if (state == EXEC && acc_we) zero <= (acc_nx == 8'h00);
    end
`endif

endmodule
